// File: rtl/fifo_pack_pkg.sv
// Shared types and sizing for the byte-to-word packer.
package fifo_pack_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      EMIT = 2'd2
   } state_e;

endpackage

// File: rtl/fifo_byte_packer.sv
// Packs bytes from a registered-output FIFO into 32-bit words, emitting partial
// words on flush or after an idle timeout.
module fifo_byte_packer
   import fifo_pack_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fifo_empty,
   input  logic [7:0]        fifo_dout,
   output logic              fifo_rd_en,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic [3:0]        out_keep,
   output logic              busy
);

   localparam int unsigned IDLE_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic                      pend_q, pend_d;
   logic                      flush_req_q, flush_req_d;
   logic [IDLE_W-1:0]         idle_q, idle_d;
   logic [WORD_W-1:0]         data_q, data_d;
   logic [BYTES_PER_WORD-1:0] keep_q, keep_d;
   logic                      valid_q, valid_d;
   logic                      busy_q, busy_d;

   logic [CNT_W-1:0]          count_cap;
   logic                      rd_en_c;
   logic                      idle_cond;
   logic                      timeout_hit;

   // Pop only while collecting and when the byte will still fit in the word.
   assign rd_en_c = rst_n && (state_q != EMIT) && !fifo_empty && !flush_req_q &&
                    ((4'(count_q) + 4'(pend_q) + 4'd1) <= 4'(BYTES_PER_WORD));

   assign idle_cond   = (state_q == FILL) && (count_q != '0) && fifo_empty && !pend_q;
   assign timeout_hit = (TIMEOUT != 0) && idle_cond && (idle_q == IDLE_LAST);
   assign count_cap   = count_q + CNT_W'(pend_q);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      pend_d      = rd_en_c;
      flush_req_d = flush_req_q;
      idle_d      = idle_q;
      data_d      = data_q;
      keep_d      = keep_q;

      if (state_q == EMIT) begin
         pend_d = 1'b0;
         if (out_ready) begin
            state_d = IDLE;
            count_d = '0;
            data_d  = '0;
            keep_d  = '0;
            idle_d  = '0;
         end
      end else begin
         if (flush) flush_req_d = 1'b1;

         if (pend_q) begin
            data_d[{count_q[1:0], 3'b000} +: 8] = fifo_dout;
            keep_d[count_q[1:0]]                = 1'b1;
            count_d                             = count_cap;
            idle_d                              = '0;
         end else if (idle_cond && (idle_q != IDLE_MAX)) begin
            idle_d = idle_q + IDLE_W'(1);
         end

         // A completed word takes priority over flush and timeout.
         if (count_cap == CNT_W'(BYTES_PER_WORD)) begin
            state_d = EMIT;
         end else if (flush_req_q && !pend_q) begin
            if (count_q != '0) begin
               state_d = EMIT;
            end else begin
               state_d     = IDLE;
               flush_req_d = flush;
            end
         end else if (timeout_hit) begin
            state_d = EMIT;
         end else begin
            state_d = ((count_cap != '0) || rd_en_c) ? FILL : IDLE;
         end

         if (state_d == EMIT) begin
            flush_req_d = 1'b0;
            idle_d      = '0;
         end
      end

      valid_d = (state_d == EMIT);
      busy_d  = (state_d != IDLE) || pend_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         pend_q      <= 1'b0;
         flush_req_q <= 1'b0;
         idle_q      <= '0;
         data_q      <= '0;
         keep_q      <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         pend_q      <= pend_d;
         flush_req_q <= flush_req_d;
         idle_q      <= idle_d;
         data_q      <= data_d;
         keep_q      <= keep_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
      end
   end

   assign fifo_rd_en = rd_en_c;
   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign out_keep   = keep_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed and randomized bench for fifo_byte_packer with a registered-output FIFO model.
module tb_fifo_byte_packer;

   logic        clk;
   logic        rst_n;
   logic        fifo_empty;
   logic [7:0]  fifo_dout;
   logic        fifo_rd_en;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   // Upstream FIFO: single writer per variable (bench pushes, model pops).
   logic [7:0] fmem [0:255];
   int         pushed_n = 0;
   int         popped_n = 0;

   // Accepted words as seen on the output handshake.
   logic [35:0] got_mem [0:63];
   int          got_w    = 0;
   int          got_r    = 0;
   int          emit_rd  = 0;
   int          stab_err = 0;
   logic        prev_hold = 1'b0;
   logic [35:0] prev_word = '0;

   fifo_byte_packer #(.TIMEOUT(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_keep   (out_keep),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign fifo_empty = (pushed_n == popped_n);

   initial fifo_dout = 8'h00;
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_dout <= fmem[popped_n[7:0]];
         popped_n  <= popped_n + 1;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            got_mem[got_w[5:0]] <= {out_keep, out_data};
            got_w               <= got_w + 1;
         end
         if (out_valid && fifo_rd_en) emit_rd <= emit_rd + 1;
         if (prev_hold && (!out_valid || ({out_keep, out_data} !== prev_word)))
            stab_err <= stab_err + 1;
         prev_hold <= out_valid && !out_ready;
         prev_word <= {out_keep, out_data};
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      fmem[pushed_n[7:0]] = b;
      pushed_n            = pushed_n + 1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                              input int budget);
      int n;
      n = 0;
      while ((got_w == got_r) && (n < budget)) begin
         step(1);
         n++;
      end
      chk({tag, "_present"}, 64'(got_w > got_r), 64'd1);
      if (got_w > got_r) begin
         chk({tag, "_data"}, 64'(got_mem[got_r[5:0]][31:0]), 64'(d));
         chk({tag, "_keep"}, 64'(got_mem[got_r[5:0]][35:32]), 64'(k));
         got_r++;
      end
   endtask

   initial begin
      int          n;
      int          base;
      int          idx;
      logic [7:0]  rb [0:47];
      logic [31:0] ew;

      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;

      // Reset with bytes already waiting: nothing may be popped or shown.
      push(8'h11);
      push(8'h22);
      step(2);
      chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data",  64'(out_data),  64'd0);
      chk("rst_keep",  64'(out_keep),  64'd0);
      chk("rst_busy",  64'(busy),      64'd0);

      rst_n     = 1'b1;
      out_ready = 1'b1;
      push(8'h33);
      push(8'h44);
      expect_word("word0", 32'h4433_2211, 4'hF, 20);

      // Backpressure: first word held, no pops while emitting.
      step(2);
      out_ready = 1'b0;
      base      = popped_n;
      for (int i = 1; i <= 8; i++) push(8'(i * 17));
      n = 0;
      while (!out_valid && (n < 20)) begin
         step(1);
         n++;
      end
      chk("hold_rise", 64'(out_valid), 64'd1);
      step(10);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data",  64'(out_data),  64'h4433_2211);
      chk("hold_keep",  64'(out_keep),  64'hF);
      chk("hold_pops",  64'(popped_n - base), 64'd4);
      out_ready = 1'b1;
      expect_word("hold_w1", 32'h4433_2211, 4'hF, 10);
      expect_word("hold_w2", 32'h8877_6655, 4'hF, 20);

      // Flush of a three-byte partial word.
      step(2);
      push(8'hA1);
      push(8'hB2);
      push(8'hC3);
      step(6);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      expect_word("flush3", 32'h00C3_B2A1, 4'b0111, 10);

      // Timeout: capture two edges after push, emission 16 cycles after capture.
      step(2);
      push(8'h5A);
      n = 0;
      while (!out_valid && (n < 40)) begin
         step(1);
         n++;
      end
      chk("timeout_latency", 64'(n), 64'd18);
      expect_word("timeout1", 32'h0000_005A, 4'b0001, 5);

      // Flush with nothing held produces nothing.
      step(2);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("idle_flush_valid", 64'(out_valid), 64'd0);
         chk("idle_flush_busy",  64'(busy),      64'd0);
         step(1);
      end
      chk("idle_flush_words", 64'(got_w - got_r), 64'd0);

      // Reset mid-word discards held bytes.
      push(8'hEE);
      push(8'hFF);
      step(5);
      rst_n = 1'b0;
      #1;
      chk("midrst_rd_en", 64'(fifo_rd_en), 64'd0);
      chk("midrst_valid", 64'(out_valid),  64'd0);
      chk("midrst_data",  64'(out_data),   64'd0);
      chk("midrst_keep",  64'(out_keep),   64'd0);
      chk("midrst_busy",  64'(busy),       64'd0);
      step(2);
      rst_n = 1'b1;
      step(1);
      for (int i = 1; i <= 4; i++) push(8'(i));
      expect_word("post_rst", 32'h0403_0201, 4'hF, 20);
      step(20);
      chk("post_rst_extra", 64'(got_w - got_r), 64'd0);

      // Random byte stream with random backpressure: words are consecutive groups of 4.
      for (int i = 0; i < 48; i++) rb[i] = 8'($urandom);
      idx = 0;
      for (int c = 0; (c < 3000) && ((got_w - got_r) < 12); c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if ((idx < 48) && ($urandom_range(0, 2) != 0)) begin
            push(rb[idx]);
            idx++;
         end
         step(1);
      end
      out_ready = 1'b1;
      for (int w = 0; w < 12; w++) begin
         for (int j = 0; j < 4; j++) ew[8*j +: 8] = rb[4*w + j];
         expect_word("rand", ew, 4'hF, 5);
      end
      step(10);
      chk("rand_extra",    64'(got_w - got_r), 64'd0);
      chk("stability",     64'(stab_err),      64'd0);
      chk("no_emit_reads", 64'(emit_rd),       64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_byte_packer.md
FIFO_BYTE_PACKER -- requirements
Module: fifo_byte_packer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: idle cycles before a partial word is emitted; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port fifo_empty, input, 1, upstream byte FIFO empty flag.
REQ-005 SHALL have port fifo_dout, input, 8, upstream FIFO read data, valid the cycle after fifo_rd_en.
REQ-006 SHALL have port fifo_rd_en, output, 1, pop request to upstream FIFO.
REQ-007 SHALL have port flush, input, 1, single-cycle request to emit any partial word.
REQ-008 SHALL have port out_valid, output, 1, packed word valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts word.
REQ-010 SHALL have port out_data, output, 32, packed word.
REQ-011 SHALL have port out_keep, output, 4, per-byte-lane valid mask.
REQ-012 SHALL have port busy, output, 1, high when state != IDLE or a read is in flight.

Function
REQ-013 SHALL implement FSM states IDLE (0 bytes held), FILL (1-3 bytes held or read in flight), EMIT (out_valid high).
REQ-014 SHALL assert fifo_rd_en combinationally when state is IDLE/FILL, !fifo_empty, no flush pending, and count + pending + 1 <= 4.
REQ-015 SHALL treat the FIFO as registered-output: byte is captured from fifo_dout exactly one cycle after fifo_rd_en; back-to-back reads allowed.
REQ-016 SHALL place the n-th captured byte (n = 0..3) in out_data[8n+7:8n] and set out_keep[n].
REQ-017 SHALL transition to EMIT the cycle after the 4th byte is captured, with out_keep = 4'hF.
REQ-018 SHALL issue no reads in EMIT.
REQ-019 SHALL hold out_data and out_keep stable while out_valid && !out_ready.
REQ-020 SHALL, on out_valid && out_ready, clear the count and lanes and go to IDLE next cycle.
REQ-021 SHALL latch flush into flush_req; flush_req blocks new reads.
REQ-022 SHALL, with flush_req set and no read in flight, enter EMIT if count > 0 (partial keep, e.g. 3 bytes -> 4'b0111), else clear flush_req and stay IDLE with no output.
REQ-023 SHALL clear flush_req on entry to EMIT.
REQ-024 SHALL ignore a flush asserted during EMIT.
REQ-025 SHALL drive unused byte lanes of a partial word as 8'h00.
REQ-026 SHALL, in FILL with count > 0, fifo_empty high and no read in flight, increment an idle counter each cycle; any captured byte clears it.
REQ-027 SHALL enter EMIT with the partial word when the idle counter reaches TIMEOUT-1, if TIMEOUT != 0.
REQ-028 SHALL size the idle counter as $clog2(TIMEOUT+1) bits, saturating and never wrapping.
REQ-029 SHALL give a simultaneous 4th byte capture and flush/timeout the full-word path (keep 4'hF), and consume the flush.

Reset
REQ-030 SHALL, on rst_n low, asynchronously force state IDLE, count 0, pending 0, flush_req 0, idle counter 0.
REQ-031 SHALL drive fifo_rd_en 0, out_valid 0, out_data 32'h0, out_keep 4'h0 and busy 0 during reset.
REQ-032 SHALL, on reset mid-operation, discard held bytes and any in-flight byte; no partial word is emitted after reset release.

Structure
REQ-033 SHALL take the state enum, BYTES_PER_WORD = 4 and WORD_W = 32 from shared package fifo_pack_pkg.
REQ-034 SHALL be a single module with no sub-modules; the timeout counter stays inline.

Verification
REQ-035 SHALL cover: FIFO holds 8'h11,22,33,44 with out_ready=1 -> one word 32'h44332211, keep 4'hF.
REQ-036 SHALL cover: 8 bytes with out_ready=0 for 10 cycles -> first word held stable; no reads in EMIT; second word 32'h88776655 after release.
REQ-037 SHALL cover: bytes 8'hA1,B2,C3 then one-cycle flush -> 32'h00C3B2A1, keep 4'b0111.
REQ-038 SHALL cover: TIMEOUT=16, one byte 8'h5A then FIFO empty -> partial word 32'h0000005A, keep 4'b0001, 16 cycles after capture.
REQ-039 SHALL cover: flush while IDLE and empty -> no out_valid; busy stays 0.
REQ-040 SHALL cover: rst_n low after 2 bytes captured -> all outputs 0; after release, bytes 8'h01,02,03,04 -> 32'h04030201 with no stale bytes.
